// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: bundles the raw coin sensors, the downstream busy input
// and the coin / reject / occupancy outputs of coin_acceptor.
// Optional: reject_cnt exists only when COIN_ACCEPTOR_REJECT_CNT_EN is defined.
interface coin_acceptor_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  logic                sense1;
  logic                sense2;
  logic                hold;
  logic [1:0]          coin;
  logic                reject;
  logic [CNT_BITS-1:0] fifo_cnt;
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
  logic [7:0]          reject_cnt;
`endif

  // Acceptor side: consumes sensors and hold, produces coin codes.
  modport master (
    input  sense1,
    input  sense2,
    input  hold,
    output coin,
    output reject,
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
    output reject_cnt,
`endif
    output fifo_cnt
  );

  // Environment side: drives sensors and hold, observes coin codes.
  modport slave (
    output sense1,
    output sense2,
    output hold,
    input  coin,
    input  reject,
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
    input  reject_cnt,
`endif
    input  fifo_cnt
  );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the two coin sensors, turns each
// debounced rising edge into a coin event, queues accepted coins in a small
// FIFO and replays them as one-cycle coin codes separated by idle gaps.
// Coincident events, or an event arriving with the FIFO full, pulse reject.
// Optional: define COIN_ACCEPTOR_REJECT_CNT_EN to add a saturating 8-bit
// reject counter (bus.reject_cnt).
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic           clk,
  input  logic           rstn,
  coin_acceptor_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  // The IDLE cycle that samples hold is the last forced zero cycle, so the
  // GAP state itself only spans GAP_CYCLES-1 cycles (0..GAP_CYCLES-2).
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Channel index 0 = sense1 (one unit), 1 = sense2 (two units).
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       lvl;
  logic [1:0]       lvl_d;
  logic [1:0]       evt;
  logic [CNT_W-1:0] db_cnt [2];

  logic             both_evt;
  logic             one_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             reject_next;
  logic             reject_q;

  logic             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;

  state_t           state;
  state_t           state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  logic [1:0]       coin_q;
  logic [1:0]       coin_next;

  // Two-flop synchroniser for both raw sensor lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {bus.sense2, bus.sense1};
      sync_b <= sync_a;
    end
  end

  // Debounce: lvl toggles only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            lvl[i]    <= ~lvl[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered one-cycle event on each debounced rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl_d <= '0;
      evt   <= '0;
    end else begin
      lvl_d <= lvl;
      evt   <= lvl & ~lvl_d;
    end
  end

  // Validation: the full test uses the occupancy before any same-cycle pop.
  assign both_evt    = evt[0] & evt[1];
  assign one_evt     = evt[0] ^ evt[1];
  assign fifo_full   = (count == CNT_FULL);
  assign fifo_empty  = (count == '0);
  assign push        = one_evt & ~fifo_full;
  assign reject_next = both_evt | (one_evt & fifo_full);

  // Registered reject pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reject_q <= 1'b0;
    end else begin
      reject_q <= reject_next;
    end
  end

  // FIFO storage: 1-bit entries, 0 = one unit, 1 = two units.
  // NOTE: storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= evt[1];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Emitter state, gap counter and registered coin output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      coin_q  <= 2'd0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      coin_q  <= coin_next;
    end
  end

  // Emitter next state: a code is loaded into coin_q on the edge leaving IDLE.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    coin_next  = 2'd0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !bus.hold) begin
          state_next = ST_EMIT;
          coin_next  = mem[rd_ptr] ? 2'd2 : 2'd1;
          pop        = 1'b1;
        end
      end
      ST_EMIT: begin
        gap_next   = '0;
        state_next = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
  logic [7:0] reject_cnt_q;

  // Saturating count of reject pulses, advanced on the edge that raises reject.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reject_cnt_q <= 8'd0;
    end else if (reject_next && (reject_cnt_q != 8'hFF)) begin
      reject_cnt_q <= reject_cnt_q + 8'd1;
    end
  end

  assign bus.reject_cnt = reject_cnt_q;
`endif

  assign bus.coin     = coin_q;
  assign bus.reject   = reject_q;
  assign bus.fifo_cnt = count;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that turns the two raw coin-sensor lines into the one-cycle `coin[1:0]` codes consumed by the vending-machine FSM. It synchronises and debounces each sensor and detects each coin insertion. Accepted coins are queued in a small FIFO and replayed downstream one at a time, with enforced idle gaps and a back-pressure input. Unusable events produce a `reject` pulse that drives the coin-return flap.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required before a sensor level change is accepted (≥2).
- `CNT_W`, 3: debounce counter width; must hold `DEBOUNCE_CYCLES`.
- `FIFO_DEPTH`, 4: queued coins, power of two.
- `GAP_CYCLES`, 2: forced `coin==0` cycles after each emitted code (≥1).

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `sense1`  in  1  raw, asynchronous one-unit coin sensor; high while a coin is in the slot.
- `sense2`  in  1  raw, asynchronous two-unit coin sensor.
- `hold`  in  1  downstream busy (tie to `pr`); blocks new emissions.
- `coin`  out  2  0 = none, 1 = one unit, 2 = two units; 3 is never driven. Registered.
- `reject`  out  1  one-cycle pulse: coin event discarded. Registered.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  coins queued.

## Operation
- **Synchronisation:** each sense line passes through a 2-flop synchroniser.
- **Debounce, per channel:**
  - Keep a debounced level `lvl`.
  - The counter increments while the synchronised value differs from `lvl`.
  - It clears whenever the two agree.
  - When the counter has counted `DEBOUNCE_CYCLES` consecutive differing samples, `lvl` toggles and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` are ignored.
  - Falling edges are debounced the same way. A second coin on the same channel registers only after the line has been low for `DEBOUNCE_CYCLES` cycles.
- **Event:** a rising edge of `lvl` creates a one-cycle event carrying code 1 (`sense1`) or 2 (`sense2`).
- **Validation:**
  - If both channels produce events in the same cycle, both are discarded and `reject` pulses.
  - A single event with FIFO full is dropped and `reject` pulses.
  - The full check uses the count before any same-cycle pop, so a push is rejected even if a pop happens that cycle.
- **FIFO:**
  - 1-bit entries (0 = code 1, 1 = code 2), circular read/write pointers.
  - Push and pop in the same cycle while not full leaves `fifo_cnt` unchanged.
- **Emitter FSM:**
  - IDLE: `coin=0`. Go to EMIT when FIFO is not empty and `hold==0`.
  - EMIT: `coin` = head code for exactly one cycle; pop the entry; go to GAP.
  - GAP: `coin=0` for `GAP_CYCLES` cycles, then IDLE. `hold` does not extend or abort GAP; it is only sampled in IDLE.
  - Unused state encodings go to IDLE with `coin=0`.
- **Reset:** while `rstn` is low, all logic is asynchronously cleared:
  - `coin=0`, `reject=0`, `fifo_cnt=0`.
  - Synchroniser flops 0, `lvl=0`, counters 0, FSM in IDLE.
  - Reset mid-emission discards the queue.
  - A sensor held high through reset produces exactly one coin event after reset (debounced level restarts at 0).

## Timing
- Latency: the first edge that samples a raw sensor high is edge 0. With an empty FIFO, FSM in IDLE and `hold=0`, `coin` is non-zero after edge `DEBOUNCE_CYCLES+4` (2 sync + `DEBOUNCE_CYCLES` debounce + 1 FIFO write + 1 emit register).
- `reject` asserts after edge `DEBOUNCE_CYCLES+3`, the same edge at which an accepted coin would have been written.
- Throughput: one coin per `1+GAP_CYCLES` cycles when `hold=0`.
- `coin` never asserts on consecutive cycles.
- `hold` rising in the same cycle the FSM leaves IDLE has no effect on that emission (`hold` is sampled at that edge).
- `fifo_cnt` updates on the edge of push/pop.

## Configuration
- `COIN_ACCEPTOR_REJECT_CNT_EN` defined:
  - Adds output `reject_cnt` [7:0].
  - Increments on every `reject` pulse, saturating at 255.
  - Reset to 0 by `rstn`.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- `sense1` high for 10 cycles, defaults → `coin==1` for exactly one cycle, 8 edges after first high sample; `reject` stays 0.
- `sense2` glitch high for 3 cycles → no `coin`, no `reject`; `fifo_cnt` stays 0.
- `sense1` and `sense2` rise in the same cycle, both held 10 cycles → one `reject` pulse, `fifo_cnt` stays 0, no `coin`.
- `hold=1`, insert coins in order 1,2,1,2,1 (each high 8 / low 8 cycles) → `fifo_cnt` reaches 4 and the fifth coin pulses `reject`. Release `hold` → `coin` sequence 1,2,1,2, each followed by exactly 2 zero cycles.
- Queue 2 coins, assert `rstn=0` during an EMIT cycle → `coin=0` and `fifo_cnt=0` immediately. After release, no codes are emitted.
- With the macro defined, generate 3 rejects → `reject_cnt==3`. Force 300 rejects → `reject_cnt==255`.
